bin_average_accumulator: RTL

BIN_AVERAGE_ACCUMULATOR -- requirements
Module: bin_average_accumulator

---
 rtl/bin_average_accumulator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bin_average_accumulator.sv
// Per-bin frame averager: sums 2^N_AVGS frames of BINS signed samples, then publishes sum >>> N_AVGS.
// Latency: final sample accepted in cycle T -> out_valid pulse and new out_data in cycle T+2.
// No backpressure: samples are taken whenever in_valid=1. Define BIN_AVG_ROUND_EN for round-half-up averaging.
module bin_average_accumulator #(
  parameter int N      = 16,
  parameter int BINS   = 4,
  parameter int N_AVGS = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   in_valid,
  input  logic [N-1:0]           in_data,
  output logic [BINS-1:0][N-1:0] out_data,
  output logic                   out_valid,
  output logic                   frame_err
);

  localparam int W  = N + N_AVGS + 1;   // holds 2^N_AVGS N-bit samples plus rounding bias
  localparam int BW = $clog2(BINS);
  localparam int FW = N_AVGS + 1;       // one spare bit so N_AVGS=0 still has a counter
  localparam logic [BW-1:0] BIN_LAST   = BW'(BINS - 1);
  localparam logic [FW-1:0] FRAME_LAST = {FW{1'b1}} >> 1;  // 2^N_AVGS - 1

`ifdef BIN_AVG_ROUND_EN
  localparam int RSH = (N_AVGS > 0) ? N_AVGS - 1 : 0;
  localparam logic signed [W-1:0] RND_ADD = (N_AVGS > 0) ? (W'(1) << RSH) : W'(0);
`else
  localparam logic signed [W-1:0] RND_ADD = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DUMP
  } state_t;

  state_t                   state_q, state_d;
  logic [BW-1:0]            bin_q, bin_d;
  logic [FW-1:0]            frame_cnt_q, frame_cnt_d;
  logic signed [W-1:0]      sum_q [BINS];
  logic signed [W-1:0]      sum_d [BINS];
  logic [BINS-1:0][N-1:0]   out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     frame_err_q, frame_err_d;

  logic signed [W-1:0]      samp_ext;
  logic                     start_acc;
  logic [BINS-1:0][N-1:0]   dump_dat;

  assign samp_ext  = {{(W-N){in_data[N-1]}}, in_data};
  assign start_acc = frame_start & in_valid;

  // Averaged view of the current sums: optional bias, arithmetic shift, keep low N bits.
  always_comb begin
    dump_dat = '0;
    for (int k = 0; k < BINS; k++) begin
      dump_dat[k] = N'((sum_q[k] + RND_ADD) >>> N_AVGS);
    end
  end

  // Frame sequencing, accumulation and output update.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    frame_cnt_d = frame_cnt_q;
    sum_d       = sum_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          sum_d[0] = sum_q[0] + samp_ext;
          bin_d    = BW'(1);
          state_d  = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (start_acc) begin
          // Truncated frame: throw the whole average set away and restart with this sample.
          frame_err_d = 1'b1;
          for (int k = 0; k < BINS; k++) sum_d[k] = '0;
          sum_d[0]    = samp_ext;
          frame_cnt_d = '0;
          bin_d       = BW'(1);
        end else if (in_valid) begin
          sum_d[bin_q] = sum_q[bin_q] + samp_ext;
          if (bin_q == BIN_LAST) begin
            bin_d       = '0;
            frame_cnt_d = frame_cnt_q + FW'(1);
            state_d     = (frame_cnt_q == FRAME_LAST) ? S_DUMP : S_IDLE;
          end else begin
            bin_d = bin_q + BW'(1);
          end
        end
      end

      S_DUMP: begin
        out_data_d  = dump_dat;
        out_valid_d = 1'b1;
        for (int k = 0; k < BINS; k++) sum_d[k] = '0;
        frame_cnt_d = '0;
        bin_d       = '0;
        state_d     = S_IDLE;
        // A frame may start right in the dump cycle; it opens the next set without loss.
        if (start_acc) begin
          sum_d[0] = samp_ext;
          bin_d    = BW'(1);
          state_d  = S_ACCUM;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      frame_cnt_q <= '0;
      for (int k = 0; k < BINS; k++) sum_q[k] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      frame_cnt_q <= frame_cnt_d;
      sum_q       <= sum_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule
